// File: rtl/lag_counter_pkg.sv
// Shared definitions for the display lag counter: widths, averaging depth,
// FSM state encoding and small arithmetic helpers.
package lag_counter_pkg;

  // Width of every lag result, in microseconds.
  localparam int unsigned LAG_WIDTH = 20;

  // Number of samples folded into one average, and the matching shift.
  localparam int unsigned AVG_SAMPLES = 16;
  localparam int unsigned AVG_SHIFT = 4;

  // Accumulator holds AVG_SAMPLES full-scale lag values without overflow.
  localparam int unsigned ACC_WIDTH = 24;
  localparam int unsigned AVG_CNT_WIDTH = 4;

  // Height in video lines of each white test field drawn by the pattern source.
  localparam int unsigned LAGLINE_SIZE = 64;

  // Largest representable lag; also the "no sample yet" value of lag_min.
  localparam logic [LAG_WIDTH-1:0] LAG_ALL_ONES = {LAG_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StResult  = 2'd2
  } lag_state_e;

  // Saturating increment: the lag counter sticks at full scale.
  function automatic logic [LAG_WIDTH-1:0] lag_sat_inc(input logic [LAG_WIDTH-1:0] v);
    return (v == LAG_ALL_ONES) ? v : v + LAG_WIDTH'(1);
  endfunction

  function automatic logic [LAG_WIDTH-1:0] lag_min_of(input logic [LAG_WIDTH-1:0] a,
                                                      input logic [LAG_WIDTH-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [LAG_WIDTH-1:0] lag_max_of(input logic [LAG_WIDTH-1:0] a,
                                                      input logic [LAG_WIDTH-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/lag_counter_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for the
// asynchronous photodiode comparator output.
module sensor_debounce
  import lag_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            level_q;
  logic            level_d;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the current level; any
  // agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Debouncer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign out = level_q;

endmodule

// File: rtl/lag_counter.sv
// Display input-lag counter: measures microseconds from a trigger frame to the
// photodiode seeing the white test field, and keeps last/min/max/average.
module lag_counter
  import lag_counter_pkg::*;
#(
  parameter int unsigned CLKS_PER_US     = 27,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_US      = 500000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     starttrigger,
  input  logic                     sensor,
  output logic                     busy,
  output logic                     lag_valid,
  output logic                     lag_timeout,
  output logic                     sensor_error,
  output logic [LAG_WIDTH-1:0]     lag_last,
  output logic [LAG_WIDTH-1:0]     lag_min,
  output logic [LAG_WIDTH-1:0]     lag_max,
  output logic [LAG_WIDTH-1:0]     lag_avg,
  output logic [AVG_CNT_WIDTH-1:0] avg_count
);

  localparam int unsigned PreW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLKS_PER_US - 1);
  localparam logic [LAG_WIDTH-1:0] TimeoutVal = LAG_WIDTH'(TIMEOUT_US);
  localparam logic [AVG_CNT_WIDTH-1:0] AvgLast = AVG_CNT_WIDTH'(AVG_SAMPLES - 1);

  logic sensor_db;

  lag_state_e               state_q, state_d;
  logic [PreW-1:0]          pre_q, pre_d;
  logic [LAG_WIDTH-1:0]     cnt_q, cnt_d;
  logic [LAG_WIDTH-1:0]     last_q, last_d;
  logic [LAG_WIDTH-1:0]     min_q, min_d;
  logic [LAG_WIDTH-1:0]     max_q, max_d;
  logic [LAG_WIDTH-1:0]     avg_q, avg_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ACC_WIDTH-1:0]     acc_sum;
  logic [AVG_CNT_WIDTH-1:0] avg_cnt_q, avg_cnt_d;
  logic                     valid_q, valid_d;
  logic                     timeout_q, timeout_d;
  logic                     error_q, error_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor_debounce (
    .clock(clock),
    .reset(reset),
    .in   (sensor),
    .out  (sensor_db)
  );

  assign acc_sum = acc_q + ACC_WIDTH'(cnt_q);

  // Next-state and result logic; the debounce latency stays inside the lag.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    avg_d     = avg_q;
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (starttrigger) begin
          // A bright sensor at trigger time means the fixture is misplaced.
          if (sensor_db) begin
            error_d = 1'b1;
          end else begin
            state_d = StMeasure;
            pre_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      StMeasure: begin
        // Timeout wins over a simultaneous sensor rise.
        if (cnt_q >= TimeoutVal) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else if (sensor_db) begin
          state_d = StResult;
        end else if (pre_q == PreLast) begin
          pre_d = '0;
          cnt_d = lag_sat_inc(cnt_q);
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end

      StResult: begin
        last_d  = cnt_q;
        min_d   = lag_min_of(min_q, cnt_q);
        max_d   = lag_max_of(max_q, cnt_q);
        valid_d = 1'b1;
        state_d = StIdle;
        if (avg_cnt_q == AvgLast) begin
          avg_d     = acc_sum[ACC_WIDTH-1:AVG_SHIFT];
          acc_d     = '0;
          avg_cnt_d = '0;
        end else begin
          acc_d     = acc_sum;
          avg_cnt_d = avg_cnt_q + AVG_CNT_WIDTH'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, counters, statistics and registered pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      min_q     <= LAG_ALL_ONES;
      max_q     <= '0;
      avg_q     <= '0;
      acc_q     <= '0;
      avg_cnt_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      avg_q     <= avg_d;
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign lag_valid    = valid_q;
  assign lag_timeout  = timeout_q;
  assign sensor_error = error_q;
  assign lag_last     = last_q;
  assign lag_min      = min_q;
  assign lag_max      = max_q;
  assign lag_avg      = avg_q;
  assign avg_count    = avg_cnt_q;

endmodule

// File: tb/tb_lag_counter.sv
// Directed bench for lag_counter. Three instances: default timing (a), a fast
// 2-clocks-per-us instance for the 16-sample average (b), and a 10 us timeout (c).
// Expected lag for a sensor edge driven d cycles after the trigger edge is
// (d + 6) / CLKS_PER_US: one cycle to be sampled plus 5 more through sync/debounce.
module tb_lag_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic trig_a, sens_a, trig_b, sens_b, trig_c, sens_c;

  logic        busy_a, valid_a, tout_a, err_a;
  logic [19:0] last_a, min_a, max_a, avg_a;
  logic [3:0]  acnt_a;
  logic        busy_b, valid_b, tout_b, err_b;
  logic [19:0] last_b, min_b, max_b, avg_b;
  logic [3:0]  acnt_b;
  logic        busy_c, valid_c, tout_c, err_c;
  logic [19:0] last_c, min_c, max_c, avg_c;
  logic [3:0]  acnt_c;

  lag_counter u_dut_a (
    .clock(clock), .reset(reset), .starttrigger(trig_a), .sensor(sens_a),
    .busy(busy_a), .lag_valid(valid_a), .lag_timeout(tout_a), .sensor_error(err_a),
    .lag_last(last_a), .lag_min(min_a), .lag_max(max_a), .lag_avg(avg_a),
    .avg_count(acnt_a)
  );

  lag_counter #(.CLKS_PER_US(2)) u_dut_b (
    .clock(clock), .reset(reset), .starttrigger(trig_b), .sensor(sens_b),
    .busy(busy_b), .lag_valid(valid_b), .lag_timeout(tout_b), .sensor_error(err_b),
    .lag_last(last_b), .lag_min(min_b), .lag_max(max_b), .lag_avg(avg_b),
    .avg_count(acnt_b)
  );

  lag_counter #(.TIMEOUT_US(10)) u_dut_c (
    .clock(clock), .reset(reset), .starttrigger(trig_c), .sensor(sens_c),
    .busy(busy_c), .lag_valid(valid_c), .lag_timeout(tout_c), .sensor_error(err_c),
    .lag_last(last_c), .lag_min(min_c), .lag_max(max_c), .lag_avg(avg_c),
    .avg_count(acnt_c)
  );

  int tests = 0;
  int failures = 0;
  int q_a[$];
  int q_b[$];
  int valid_cnt_a = 0, valid_cnt_b = 0, valid_cnt_c = 0;
  int tout_cnt_a = 0, tout_cnt_c = 0;
  int err_cnt_a = 0;
  int n;
  int lag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  function automatic logic busy_of(input int k);
    case (k)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wait_idle(input int k, input int budget, input string tag);
    int waited = 0;
    while (busy_of(k) === 1'b1 && waited < budget) begin
      tick(1);
      waited++;
    end
    check({tag, "_idle_in_budget"}, busy_of(k), 1'b0);
  endtask

  // Scoreboard: each lag_valid pops the next expected lag_last.
  always @(negedge clock) begin
    if (valid_a === 1'b1) begin
      valid_cnt_a++;
      check("a_result_expected", q_a.size() > 0, 1'b1);
      if (q_a.size() > 0) check("a_lag_last", last_a, q_a.pop_front());
    end
    if (valid_b === 1'b1) begin
      valid_cnt_b++;
      check("b_result_expected", q_b.size() > 0, 1'b1);
      if (q_b.size() > 0) check("b_lag_last", last_b, q_b.pop_front());
    end
    if (valid_c === 1'b1) valid_cnt_c++;
    if (tout_a === 1'b1) tout_cnt_a++;
    if (tout_c === 1'b1) tout_cnt_c++;
    if (err_a === 1'b1) err_cnt_a++;
  end

  initial begin
    reset = 1'b1;
    trig_a = 1'b0; sens_a = 1'b0;
    trig_b = 1'b0; sens_b = 1'b0;
    trig_c = 1'b0; sens_c = 1'b0;
    tick(3);
    check("rst_busy", busy_a, 1'b0);
    check("rst_lag_min", min_a, 20'hFFFFF);
    check("rst_lag_max", max_a, 0);
    check("rst_lag_last", last_a, 0);
    check("rst_lag_avg", avg_a, 0);
    check("rst_avg_count", acnt_a, 0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_timeout", tout_a, 1'b0);
    check("rst_error", err_a, 1'b0);
    reset = 1'b0;
    tick(2);

    // Basic 100 us measurement.
    q_a.push_back(100);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    check("a_busy_measuring", busy_a, 1'b1);
    tick(2700); sens_a = 1'b1;
    wait_idle(0, 100, "a_100us");
    tick(1);
    check("a_valid_once", valid_cnt_a, 1);
    check("a_min_100", min_a, 100);
    check("a_max_100", max_a, 100);
    sens_a = 1'b0; tick(10);

    // Trigger while already bright is rejected.
    sens_a = 1'b1; tick(10);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    check("a_sensor_error_pulse", err_a, 1'b1);
    check("a_busy_on_error", busy_a, 1'b0);
    tick(5);
    check("a_busy_after_error", busy_a, 1'b0);
    check("a_error_count", err_cnt_a, 1);
    check("a_no_valid_on_error", valid_cnt_a, 1);
    sens_a = 1'b0; tick(10);

    // 3-cycle glitch must not end the measurement.
    q_a.push_back(200);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    tick(1000); sens_a = 1'b1;
    tick(3); sens_a = 1'b0;
    tick(5400 - 1003); sens_a = 1'b1;
    wait_idle(0, 100, "a_glitch");
    tick(1);
    check("a_valid_after_glitch", valid_cnt_a, 2);
    check("a_min_keep", min_a, 100);
    check("a_max_200", max_a, 200);
    sens_a = 1'b0; tick(10);

    // Second trigger mid-measurement is ignored.
    q_a.push_back(150);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    tick(500);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    check("a_busy_retrigger", busy_a, 1'b1);
    tick(4050 - 501); sens_a = 1'b1;
    wait_idle(0, 100, "a_retrigger");
    tick(1);
    check("a_valid_retrigger", valid_cnt_a, 3);
    check("a_max_stays_200", max_a, 200);
    sens_a = 1'b0; tick(10);

    // Timeout instance.
    trig_c = 1'b1; tick(1); trig_c = 1'b0;
    n = 0;
    while (tout_c !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check("c_timeout_seen", tout_c, 1'b1);
    check("c_timeout_latency", (n >= 265 && n <= 275), 1'b1);
    check("c_busy_after_timeout", busy_c, 1'b0);
    check("c_last_unchanged", last_c, 0);
    check("c_min_unchanged", min_c, 20'hFFFFF);
    check("c_max_unchanged", max_c, 0);
    check("c_avg_count_unchanged", acnt_c, 0);
    tick(2);
    trig_c = 1'b1; tick(1); trig_c = 1'b0;
    check("c_next_trigger_accepted", busy_c, 1'b1);
    wait_idle(2, 400, "c_second_timeout");
    tick(1);
    check("c_timeout_count2", tout_cnt_c, 2);
    // Sensor rises in the very cycle lag_cnt reaches the limit.
    tick(2);
    trig_c = 1'b1; tick(1); trig_c = 1'b0;
    tick(264); sens_c = 1'b1;
    wait_idle(2, 400, "c_priority");
    tick(1);
    check("c_timeout_priority", tout_cnt_c, 3);
    check("c_no_valid", valid_cnt_c, 0);
    check("c_last_still_0", last_c, 0);
    sens_c = 1'b0; tick(10);

    // Sixteen measurements 100..1600 us on the fast instance.
    for (int i = 1; i <= 16; i++) begin
      lag = 100 * i;
      q_b.push_back(lag);
      trig_b = 1'b1; tick(1); trig_b = 1'b0;
      tick(2 * lag - 6); sens_b = 1'b1;
      wait_idle(1, 50, "b_meas");
      tick(1);
      check("b_avg_count", acnt_b, i % 16);
      if (i == 15) check("b_avg_before_16th", avg_b, 0);
      sens_b = 1'b0; tick(10);
    end
    check("b_min", min_b, 100);
    check("b_max", max_b, 1600);
    check("b_avg", avg_b, 850);
    check("b_avg_count_wrapped", acnt_b, 0);
    check("b_valid_count", valid_cnt_b, 16);
    check("b_queue_drained", q_b.size(), 0);

    // Reset in the middle of a measurement.
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    tick(100);
    reset = 1'b1; tick(2);
    check("rst_mid_busy", busy_a, 1'b0);
    check("rst_mid_min", min_a, 20'hFFFFF);
    check("rst_mid_max", max_a, 0);
    reset = 1'b0;
    tick(3000);
    check("rst_mid_no_valid", valid_cnt_a, 3);
    check("rst_mid_no_timeout", tout_cnt_a, 0);
    check("rst_mid_idle", busy_a, 1'b0);
    check("a_queue_drained", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/lag_counter.md
LAG_COUNTER -- requirements
Module: lag_counter

Interface
REQ-001 Parameter CLKS_PER_US, default 27: clock cycles per microsecond.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive equal synchronised sensor samples needed for the debounced level to change.
REQ-003 Parameter TIMEOUT_US, default 500000: abort limit for one measurement, in microseconds.
REQ-004 clock  in  1  single system clock (pixel clock domain); all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 starttrigger  in  1  one-cycle pulse marking the frame where the white test fields first appear.
REQ-007 sensor  in  1  asynchronous photodiode comparator output; 1 = bright.
REQ-008 busy  out  1  high while a measurement is in progress.
REQ-009 lag_valid  out  1  one-cycle pulse; lag_last, lag_min and lag_max are updated in the same cycle.
REQ-010 lag_timeout  out  1  one-cycle pulse when a measurement is aborted.
REQ-011 sensor_error  out  1  one-cycle pulse when a trigger is rejected.
REQ-012 lag_last, lag_min, lag_max, lag_avg  out  20 each  results in microseconds.
REQ-013 avg_count  out  4  number of samples accumulated toward the next average.

Function
REQ-014 sensor shall pass through a 2-flop synchroniser, then a debouncer; the result is sensor_db.
REQ-015 sensor_db shall take a new level only after DEBOUNCE_CYCLES consecutive synchronised samples at that level.
REQ-016 FSM states: IDLE, MEASURE, RESULT.
REQ-017 IDLE: if starttrigger is high and sensor_db is 0, the FSM shall go to MEASURE and clear the prescaler and lag_cnt.
REQ-018 IDLE: if starttrigger is high and sensor_db is 1, the FSM shall stay in IDLE and pulse sensor_error for one cycle.
REQ-019 MEASURE: the prescaler shall count 0 to CLKS_PER_US-1 and wrap; lag_cnt shall increment on each wrap.
REQ-020 MEASURE: when sensor_db is 1, the FSM shall go to RESULT and freeze lag_cnt.
REQ-021 MEASURE: when lag_cnt reaches TIMEOUT_US, the FSM shall pulse lag_timeout, return to IDLE and leave all statistics unchanged.
REQ-022 If sensor_db rises in the same cycle lag_cnt reaches TIMEOUT_US, the timeout shall take priority.
REQ-023 starttrigger shall be ignored in MEASURE and RESULT.
REQ-024 RESULT, one cycle: lag_last <= lag_cnt; lag_min <= min(lag_min, lag_cnt); lag_max <= max(lag_max, lag_cnt); lag_valid pulses; then IDLE.
REQ-025 Averaging: a 24-bit accumulator shall add lag_cnt on every RESULT and avg_count shall increment.
REQ-026 On the 16th sample, lag_avg <= (accumulator + lag_cnt) >> 4, and the accumulator and avg_count shall clear to 0.
REQ-027 busy shall be 1 in MEASURE and RESULT, else 0.
REQ-028 Arithmetic: lag_cnt is unsigned 20-bit and saturates (no wrap); 20 bits covers TIMEOUT_US.
REQ-029 Measured lag = floor(cycles from the trigger cycle to the sensor_db rise / CLKS_PER_US).
REQ-030 The fixed synchroniser and debounce latency of 2+DEBOUNCE_CYCLES cycles shall be included in the measured lag, not compensated.

Reset
REQ-031 Reset shall set: FSM to IDLE; all pulse outputs and busy to 0; lag_last, lag_max, lag_avg to 0; lag_min to 20'hFFFFF.
REQ-032 Reset shall clear the accumulator, avg_count, prescaler and lag_cnt; synchroniser and debouncer to 0.
REQ-033 Reset asserted mid-measurement shall abort it with no lag_valid or lag_timeout pulse.

Structure
REQ-034 LAG_WIDTH (20), AVG_SAMPLES (16) and the FSM state encodings shall be defined in the shared defines file, alongside LAGLINE_SIZE.
REQ-035 The synchroniser and debouncer shall be one sub-module, sensor_debounce (ports clock, reset, in, out), with parameter DEBOUNCE_CYCLES.

Verification
REQ-036 Trigger with dark sensor; sensor goes high 2700 cycles later -> lag_valid once; lag_last=100, lag_min=100, lag_max=100.
REQ-037 Sensor held high, then trigger -> sensor_error pulse; busy stays 0; no lag_valid.
REQ-038 TIMEOUT_US=10, sensor never high -> lag_timeout ~270 cycles after trigger; statistics unchanged; next trigger accepted.
REQ-039 16 measurements of 100,200,...,1600 us -> lag_min=100, lag_max=1600, lag_avg=850, avg_count back to 0.
REQ-040 Sensor glitch high for 3 cycles, then a genuine rise at 5400 cycles -> lag_last=200.
REQ-041 Second trigger during MEASURE -> ignored, lag referenced to first trigger; reset mid-MEASURE -> no pulses, busy 0, lag_min=20'hFFFFF.
